// File: rtl/register_file_sb.sv
// Integer register file with per-register busy (scoreboard) bits, combinational reads
// and optional write-to-read forwarding. Index 0 and indices >= NREGS are hardwired to zero.
module register_file_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic [AW-1:0]   rd,
    input  logic            RUWr,
    input  logic [XLEN-1:0] wdata,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_rd,
    input  logic            flush,
    output logic [XLEN-1:0] output_rs1,
    output logic [XLEN-1:0] output_rs2,
    output logic            busy_rs1,
    output logic            busy_rs2,
    output logic            stall
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Loops start at 1 so index 0 is never written, and out-of-range indices never match.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int i = 1; i < NREGS; i++) begin
            if (RUWr && rd == AW'(i)) begin
                regs_d[i] = wdata;
                busy_d[i] = 1'b0;
            end
        end
        if (flush) begin
            busy_d = '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (rsv_en && rsv_rd == AW'(i)) begin
                    busy_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Forwarding overrides both the stored value and a same-cycle reservation.
    always_comb begin
        output_rs1 = '0;
        output_rs2 = '0;
        busy_rs1   = 1'b0;
        busy_rs2   = 1'b0;
        for (int i = 1; i < NREGS; i++) begin
            if (rs1 == AW'(i)) begin
                output_rs1 = regs_q[i];
                busy_rs1   = busy_q[i];
                if (BYPASS != 0 && RUWr && rd == AW'(i)) begin
                    output_rs1 = wdata;
                    busy_rs1   = 1'b0;
                end
            end
            if (rs2 == AW'(i)) begin
                output_rs2 = regs_q[i];
                busy_rs2   = busy_q[i];
                if (BYPASS != 0 && RUWr && rd == AW'(i)) begin
                    output_rs2 = wdata;
                    busy_rs2   = 1'b0;
                end
            end
        end
        if (rst) begin
            output_rs1 = '0;
            output_rs2 = '0;
            busy_rs1   = 1'b0;
            busy_rs2   = 1'b0;
        end
        stall = busy_rs1 | busy_rs2;
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Randomized and directed checks of register_file_sb in two configurations
// (32 regs with forwarding, 24 regs without) against an array-based reference model.
module tb_register_file_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1, rs2, rd, rsv_rd;
    logic        RUWr, rsv_en, flush;
    logic [31:0] wdata;

    logic [31:0] out1_a, out2_a, out1_b, out2_b;
    logic        b1_a, b2_a, st_a, b1_b, b2_b, st_b;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem   [2][32];
    logic        mbusy [2][32];
    int          nregs [2] = '{32, 24};
    int          byp   [2] = '{1, 0};

    always #5 clk = ~clk;

    register_file_sb #(.XLEN(32), .NREGS(32), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd(rd), .RUWr(RUWr),
        .wdata(wdata), .rsv_en(rsv_en), .rsv_rd(rsv_rd), .flush(flush),
        .output_rs1(out1_a), .output_rs2(out2_a), .busy_rs1(b1_a),
        .busy_rs2(b2_a), .stall(st_a)
    );

    register_file_sb #(.XLEN(32), .NREGS(24), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd(rd), .RUWr(RUWr),
        .wdata(wdata), .rsv_en(rsv_en), .rsv_rd(rsv_rd), .flush(flush),
        .output_rs1(out1_b), .output_rs2(out2_b), .busy_rs1(b1_b),
        .busy_rs2(b2_b), .stall(st_b)
    );

    // ---------------- reference model ----------------
    function automatic bit legal(int c, logic [4:0] idx);
        return idx != 0 && int'(idx) < nregs[c];
    endfunction

    function automatic void exp_read(input int c, input logic [4:0] idx,
                                     output logic [31:0] d, output logic b);
        d = 32'h0;
        b = 1'b0;
        if (!rst && legal(c, idx)) begin
            if (byp[c] == 1 && RUWr && rd == idx) begin
                d = wdata;
            end else begin
                d = mem[c][idx];
                b = mbusy[c][idx];
            end
        end
    endfunction

    function automatic logic [66:0] exp_vec(int c);
        logic [31:0] d1, d2;
        logic        q1, q2;
        exp_read(c, rs1, d1, q1);
        exp_read(c, rs2, d2, q2);
        return {d1, d2, q1, q2, q1 | q2};
    endfunction

    function automatic logic [66:0] obs_vec(int c);
        if (c == 0) return {out1_a, out2_a, b1_a, b2_a, st_a};
        return {out1_b, out2_b, b1_b, b2_b, st_b};
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 32; i++) begin
                mem[c][i]   = 32'h0;
                mbusy[c][i] = 1'b0;
            end
    endfunction

    function automatic void model_edge();
        if (rst) return;
        for (int c = 0; c < 2; c++) begin
            if (RUWr && legal(c, rd)) begin
                mem[c][rd]   = wdata;
                mbusy[c][rd] = 1'b0;
            end
            if (flush) begin
                for (int i = 0; i < 32; i++) mbusy[c][i] = 1'b0;
            end else if (rsv_en && legal(c, rsv_rd)) begin
                mbusy[c][rsv_rd] = 1'b1;
            end
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        RUWr = 0; rsv_en = 0; flush = 0; rd = 0; rsv_rd = 0; wdata = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        idle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle();
        rs1 = 0; rs2 = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            rs1 = 5'($urandom_range(0, 31));
            rs2 = 5'($urandom_range(0, 31));
            RUWr = 1; rd = rs1; wdata = $urandom; rsv_en = 1; rsv_rd = rs2;
            #1;
            n_vec++;
            if ({obs_vec(0), obs_vec(1)} !== 134'h0) begin
                n_err++;
                $display("FAIL reset_outputs: got %h %h, required 0", obs_vec(0), obs_vec(1));
            end
            tick();
        end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_write_read();
        RUWr = 1; rd = 5; wdata = 32'hDEADBEEF; rs1 = 5; rs2 = 0;
        #1;
        n_vec++;
        if (obs_vec(1) !== exp_vec(1)) begin
            n_err++;
            $display("FAIL write_read_b_pre: got %h, required %h", obs_vec(1), exp_vec(1));
        end
        tick();
        rs1 = 5;
        #1;
        n_vec++;
        if (out1_a !== 32'hDEADBEEF || b1_a !== 1'b0) begin
            n_err++;
            $display("FAIL write_read_x5: got %h busy %b, required deadbeef busy 0", out1_a, b1_a);
        end
        n_vec++;
        if (obs_vec(1) !== exp_vec(1)) begin
            n_err++;
            $display("FAIL write_read_b: got %h, required %h", obs_vec(1), exp_vec(1));
        end
        $display("write x5 -> rs1 %h busy %b", out1_a, b1_a);
    endtask

    task automatic test_x0();
        RUWr = 1; rd = 0; wdata = 32'h1234; rsv_en = 1; rsv_rd = 0;
        tick();
        rs2 = 0;
        #1;
        n_vec++;
        if (out2_a !== 32'h0 || b2_a !== 1'b0 || st_a !== 1'b0) begin
            n_err++;
            $display("FAIL x0_ignored: got %h busy %b stall %b, required 0 0 0", out2_a, b2_a, st_a);
        end
        $display("x0 write+reserve -> rs2 %h busy %b", out2_a, b2_a);
    endtask

    task automatic test_bypass();
        rsv_en = 1; rsv_rd = 7;
        tick();
        rs1 = 7; rs2 = 0;
        #1;
        n_vec++;
        if (b1_a !== 1'b1 || st_a !== 1'b1) begin
            n_err++;
            $display("FAIL reserve_x7: got busy %b stall %b, required 1 1", b1_a, st_a);
        end
        RUWr = 1; rd = 7; wdata = 32'h55;
        #1;
        n_vec++;
        if (out1_a !== 32'h55 || b1_a !== 1'b0 || st_a !== 1'b0) begin
            n_err++;
            $display("FAIL bypass_x7: got %h busy %b stall %b, required 55 0 0", out1_a, b1_a, st_a);
        end
        n_vec++;
        if (obs_vec(1) !== exp_vec(1)) begin
            n_err++;
            $display("FAIL nobypass_x7: got %h, required %h", obs_vec(1), exp_vec(1));
        end
        $display("bypass x7 -> rs1 %h busy %b", out1_a, b1_a);
        tick();
    endtask

    task automatic test_same_cycle();
        RUWr = 1; rd = 9; wdata = 32'hAA; rsv_en = 1; rsv_rd = 9; rs1 = 9;
        #1;
        n_vec++;
        if (out1_a !== 32'hAA || b1_a !== 1'b0) begin
            n_err++;
            $display("FAIL bypass_rsv_x9: got %h busy %b, required aa 0", out1_a, b1_a);
        end
        tick();
        #1;
        n_vec++;
        if (out1_a !== 32'hAA || b1_a !== 1'b1) begin
            n_err++;
            $display("FAIL wr_rsv_x9: got %h busy %b, required aa 1", out1_a, b1_a);
        end
        flush = 1; rsv_en = 1; rsv_rd = 3;
        tick();
        rs2 = 3;
        #1;
        n_vec++;
        if (b1_a !== 1'b0 || b2_a !== 1'b0 || out1_a !== 32'hAA) begin
            n_err++;
            $display("FAIL flush_x9: got %h busy %b/%b, required aa 0/0", out1_a, b1_a, b2_a);
        end
        $display("write+reserve x9, flush -> rs1 %h busy %b", out1_a, b1_a);
    endtask

    task automatic test_async_reset();
        rsv_en = 1; rsv_rd = 3;
        tick();
        rsv_en = 1; rsv_rd = 4;
        tick();
        RUWr = 1; rd = 4; wdata = 32'h77;
        tick();
        rs1 = 4; rs2 = 3;
        #1;
        n_vec++;
        if (out1_a !== 32'h77 || b2_a !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset: got %h busy3 %b, required 77 1", out1_a, b2_a);
        end
        #1 rst = 1'b1;
        model_reset();
        #1;
        n_vec++;
        if ({obs_vec(0), obs_vec(1)} !== 134'h0) begin
            n_err++;
            $display("FAIL async_reset: got %h %h, required 0", obs_vec(0), obs_vec(1));
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (out1_a !== 32'h0 || b1_a !== 1'b0 || b2_a !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_state: got %h busy %b/%b, required 0 0/0", out1_a, b1_a, b2_a);
        end
        $display("async reset -> x4 %h busy %b/%b", out1_a, b1_a, b2_a);
        tick();
    endtask

    task automatic test_out_of_range();
        RUWr = 1; rd = 30; wdata = 32'h99;
        tick();
        rs2 = 30;
        #1;
        n_vec++;
        if (out2_b !== 32'h0 || b2_b !== 1'b0 || out2_a !== 32'h99) begin
            n_err++;
            $display("FAIL x30: got b %h a %h, required b 0 a 99", out2_b, out2_a);
        end
        RUWr = 1; rd = 10; wdata = 32'h42; rs1 = 10;
        #1;
        n_vec++;
        if (out1_b !== mem[1][10] || out1_b === 32'h42) begin
            n_err++;
            $display("FAIL x10_old: got %h, required %h", out1_b, mem[1][10]);
        end
        tick();
        rs1 = 10;
        #1;
        n_vec++;
        if (out1_b !== 32'h42) begin
            n_err++;
            $display("FAIL x10_new: got %h, required 42", out1_b);
        end
        $display("nregs24 x30 -> %h, x10 -> %h", out2_b, out1_b);
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            RUWr   = 1'($urandom_range(0, 1));
            rd     = 5'($urandom_range(0, 31));
            wdata  = $urandom;
            rsv_en = 1'($urandom_range(0, 1));
            rsv_rd = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            flush  = ($urandom_range(0, 15) == 0);
            rs1    = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            rs2    = ($urandom_range(0, 3) == 0) ? rsv_rd : 5'($urandom_range(0, 31));
            #1;
            for (int c = 0; c < 2; c++) begin
                n_vec++;
                if (obs_vec(c) !== exp_vec(c)) begin
                    n_err++;
                    $display("FAIL random cfg%0d cyc%0d: got %h, required %h", c, k, obs_vec(c), exp_vec(c));
                end
            end
            if (k % 50 == 0)
                $display("random cyc %0d rs1=%0d rs2=%0d -> %h %h", k, rs1, rs2, out1_a, out2_a);
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_x0();
        test_bypass();
        test_same_cycle();
        test_async_reset();
        test_out_of_range();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/register_file_sb.md
REGISTER_FILE_SB -- requirements
Module: register_file_sb

Interface
REQ-001 The block SHALL provide parameter XLEN, default 32, data width of each register.
REQ-002 The block SHALL provide parameter NREGS, default 32, number of architectural registers; legal range 2..64.
REQ-003 The block SHALL provide parameter BYPASS, default 1; 1 means write-to-read forwarding, 0 means none.
REQ-004 The block SHALL derive localparam AW = $clog2(NREGS) for all register index ports.
REQ-005 The block SHALL provide port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-006 The block SHALL provide port rst, input, 1, asynchronous active-high reset.
REQ-007 The block SHALL provide ports rs1 and rs2, input, AW each, read indices.
REQ-008 The block SHALL provide ports rd, input, AW, and RUWr, input, 1, the write index and write enable.
REQ-009 The block SHALL provide port wdata, input, XLEN, write data.
REQ-010 The block SHALL provide ports rsv_en, input, 1, and rsv_rd, input, AW, which reserve a pending write (mark busy).
REQ-011 The block SHALL provide port flush, input, 1, which clears every busy bit.
REQ-012 The block SHALL provide ports output_rs1 and output_rs2, output, XLEN each, read data.
REQ-013 The block SHALL provide ports busy_rs1 and busy_rs2, output, 1 each, pending-write flags of the read operands.
REQ-014 The block SHALL provide port stall, output, 1, equal to busy_rs1 OR busy_rs2.

Function
REQ-015 Reads SHALL be combinational (zero latency) from rs1/rs2 to output_rsX, busy_rsX and stall.
REQ-016 Index 0 SHALL read as zero with busy 0; writes and reservations to index 0 SHALL be ignored.
REQ-017 Any index >= NREGS SHALL read as zero with busy 0; writes and reservations to it SHALL be ignored.
REQ-018 On a rising edge with RUWr=1 and a legal nonzero rd, the register SHALL take wdata and its busy bit SHALL clear.
REQ-019 On a rising edge with rsv_en=1 and a legal nonzero rsv_rd, that busy bit SHALL set.
REQ-020 If RUWr and rsv_en target the same register in the same cycle, the data SHALL be written and the busy bit SHALL end set (reservation wins).
REQ-021 If flush=1, all busy bits SHALL clear at the edge; a same-cycle rsv_en SHALL be ignored; a same-cycle RUWr write SHALL still occur.
REQ-022 With BYPASS=1 and RUWr=1, legal nonzero rd equal to rsX: output_rsX SHALL equal wdata and busy_rsX SHALL be 0 in the same cycle.
REQ-023 With BYPASS=1, REQ-022 SHALL still apply when rsv_en targets the same register in that cycle; busy_rsX reads 1 from the next cycle.
REQ-024 With BYPASS=0, output_rsX SHALL show stored contents and busy_rsX the stored busy bit; a write is visible from the next cycle.
REQ-025 Busy state SHALL be one bit per register; repeated reservations SHALL NOT count; one write clears the bit.

Reset
REQ-026 Asserting rst SHALL immediately, without a clock edge, clear all registers to 0 and all busy bits to 0.
REQ-027 While rst=1, all outputs SHALL read 0 and RUWr, rsv_en and flush SHALL have no effect.
REQ-028 An operation in the same cycle that rst deasserts SHALL take effect at the first rising edge with rst=0.

Verification
REQ-029 Reset, then write 0xDEADBEEF to x5 -> next cycle rs1=5 gives output_rs1=0xDEADBEEF, busy_rs1=0.
REQ-030 Write 0x1234 to x0; reserve x0 -> rs2=0 gives output_rs2=0, busy_rs2=0, stall=0.
REQ-031 Reserve x7; next cycle rs1=7 -> busy_rs1=1, stall=1; write 0x55 to x7 with BYPASS=1 -> same cycle output_rs1=0x55, busy_rs1=0, stall=0.
REQ-032 Same-cycle write 0xAA and reserve on x9 -> next cycle x9 holds 0xAA, busy=1; flush -> busy=0.
REQ-033 Reserve x3 and x4 and write 0x77 to x4, then assert rst mid-cycle -> asynchronously x4 reads 0, both busy bits 0.
REQ-034 NREGS=24, BYPASS=0: write 0x99 to x30 -> reads 0; write 0x42 to x10 -> old value same cycle, 0x42 next cycle.
